wash_cycle_sequencer: RTL

Program sequencer for the washer. It runs a complete wash program (fill, agitate, drain, optional rinse passes, then spin) from a single start pulse. It generates the agitate and spin timing internally and supervises the fill and drain sensors with a timeout. Its valve, shake_mode and turn_mode outputs drive the washer's actuators; its busy/done/fault outputs report status to the front panel.

---
 rtl/wash_cycle_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wash_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wash_cycle_sequencer
// Purpose  : Washer program sequencer: fill, agitate, drain, rinse passes and
//            spin. Fill and drain are supervised by a sensor timeout.
// Revision : 1.0  initial release
// ============================================================================
module wash_cycle_sequencer #(
    parameter int AGITATE_CYCLES = 16,
    parameter int SPIN_CYCLES    = 32,
    parameter int FILL_TIMEOUT   = 64,
    parameter int RINSES         = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       full,
    input  logic       empty,
    input  logic       dry,
    input  logic       abort,
    output logic       valve,
    output logic       drain,
    output logic       shake_mode,
    output logic       turn_mode,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] pass
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fill    = 3'd1;
    localparam logic [2:0] c_st_agitate = 3'd2;
    localparam logic [2:0] c_st_drain   = 3'd3;
    localparam logic [2:0] c_st_spin    = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;
    localparam logic [2:0] c_st_fault   = 3'd6;

    localparam logic [15:0] c_agitate_last = 16'(AGITATE_CYCLES - 1);
    localparam logic [15:0] c_spin_last    = 16'(SPIN_CYCLES - 1);
    localparam logic [15:0] c_timeout_last = 16'(FILL_TIMEOUT - 1);
    localparam logic [15:0] c_timer_max    = 16'hFFFF;
    localparam logic [3:0]  c_rinses       = 4'(RINSES);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_timer;
    logic [3:0]  r_pass;
    logic [3:0]  w_pass_next;
    logic        w_timed;

    logic r_valve, r_drain, r_shake, r_turn, r_busy, r_done, r_fault;

    assign w_timed = (r_state == c_st_fill) || (r_state == c_st_agitate) ||
                     (r_state == c_st_drain) || (r_state == c_st_spin);

    always_comb begin
        w_state_next = r_state;
        w_pass_next  = r_pass;
        if (abort && (r_state != c_st_idle)) begin
            w_state_next = c_st_idle;
            w_pass_next  = 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_state_next = c_st_fill;
                        w_pass_next  = 4'd0;
                    end
                end
                c_st_fill: begin
                    if (full)
                        w_state_next = c_st_agitate;
                    else if (r_timer == c_timeout_last)
                        w_state_next = c_st_fault;
                end
                c_st_agitate: begin
                    if (r_timer == c_agitate_last)
                        w_state_next = c_st_drain;
                end
                c_st_drain: begin
                    if (empty) begin
                        if (r_pass < c_rinses) begin
                            w_pass_next  = r_pass + 4'd1;
                            w_state_next = c_st_fill;
                        end else begin
                            w_state_next = c_st_spin;
                        end
                    end else if (r_timer == c_timeout_last) begin
                        w_state_next = c_st_fault;
                    end
                end
                c_st_spin: begin
                    if (dry || (r_timer == c_spin_last))
                        w_state_next = c_st_done;
                end
                c_st_done:  w_state_next = c_st_idle;
                c_st_fault: w_state_next = c_st_fault;
                default:    w_state_next = c_st_idle;
            endcase
        end
    end

    // Outputs are registered from the next state so they update with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_timer <= 16'd0;
            r_pass  <= 4'd0;
            r_valve <= 1'b0;
            r_drain <= 1'b0;
            r_shake <= 1'b0;
            r_turn  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pass  <= w_pass_next;
            if (w_state_next != r_state)
                r_timer <= 16'd0;
            else if (w_timed && (r_timer != c_timer_max))
                r_timer <= r_timer + 16'd1;
            r_valve <= (w_state_next == c_st_fill);
            r_shake <= (w_state_next == c_st_agitate);
            r_turn  <= (w_state_next == c_st_spin);
            r_drain <= (w_state_next == c_st_drain) || (w_state_next == c_st_fault);
            r_busy  <= (w_state_next == c_st_fill) || (w_state_next == c_st_agitate) ||
                       (w_state_next == c_st_drain) || (w_state_next == c_st_spin);
            r_done  <= (w_state_next == c_st_done);
            r_fault <= (w_state_next == c_st_fault);
        end
    end

    assign valve      = r_valve;
    assign drain      = r_drain;
    assign shake_mode = r_shake;
    assign turn_mode  = r_turn;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign pass       = r_pass;

endmodule
`default_nettype wire
